// File: rtl/msrv32_rf_pkg.sv
// Shared definitions for the msrv32 register file with scoreboard:
// FSM state encoding, default sizes and writeback port indices.
package msrv32_rf_pkg;

    // Default data width and register count.
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Number of writeback ports and their roles.
    localparam int NWP     = 2;
    localparam int WB_ALU  = 0;
    localparam int WB_LOAD = 1;

    // Array state: sweeping zeroes into the array, or normal operation.
    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/msrv32_rf_read_port.sv
// One combinational read path of the register file: zero-detect on x0,
// priority bypass from the two writeback ports (load over ALU), and
// pending-write flag forwarding that agrees with the data bypass.
module msrv32_rf_read_port
    import msrv32_rf_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = 5
) (
    input  logic                run,
    input  logic [AW-1:0]       rs_addr,
    input  logic [XLEN-1:0]     stored_data,
    input  logic                stored_busy,
    input  logic [NWP-1:0]      wr_eff,
    input  logic [NWP*AW-1:0]   wr_addr,
    input  logic [NWP*XLEN-1:0] wr_data,
    output logic [XLEN-1:0]     rs_data,
    output logic                rs_busy
);

    logic hit_alu;
    logic hit_load;

    // wr_eff is already qualified with RUN and a non-zero address.
    assign hit_alu  = wr_eff[WB_ALU]  && (wr_addr[WB_ALU*AW  +: AW] == rs_addr);
    assign hit_load = wr_eff[WB_LOAD] && (wr_addr[WB_LOAD*AW +: AW] == rs_addr);

    // Select read data and busy: x0 and CLEAR read as zero, load bypass beats ALU bypass.
    always_comb begin
        // NOTE: outputs get a default first so every path assigns them and no latch is inferred.
        rs_data = '0;
        rs_busy = 1'b0;
        if (run && (rs_addr != '0)) begin
            if (hit_load) begin
                rs_data = wr_data[WB_LOAD*XLEN +: XLEN];
            end else if (hit_alu) begin
                rs_data = wr_data[WB_ALU*XLEN +: XLEN];
            end else begin
                rs_data = stored_data;
                rs_busy = stored_busy;
            end
        end
    end

endmodule

// File: rtl/msrv32_reg_file_sb.sv
// msrv32 integer register file: NRD combinational read ports, two writeback
// ports (ALU, load) with write-through bypass, a per-register pending-write
// scoreboard, and a one-register-per-cycle clear sweep after reset or on request.
module msrv32_reg_file_sb
    import msrv32_rf_pkg::*;
#(
    parameter int  XLEN  = XLEN_DEF,
    parameter int  NREGS = NREGS_DEF,
    parameter int  NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                ms_riscv32_mp_clk_in,
    input  logic                ms_riscv32_mp_rst_n_in,
    input  logic                clear_req_in,
    output logic                rf_ready_out,
    input  logic [NRD*AW-1:0]   rs_addr_in,
    output logic [NRD*XLEN-1:0] rs_data_out,
    output logic [NRD-1:0]      rs_busy_out,
    input  logic [NWP-1:0]      wr_en_in,
    input  logic [NWP*AW-1:0]   wr_addr_in,
    input  logic [NWP*XLEN-1:0] wr_data_in,
    input  logic                issue_en_in,
    input  logic [AW-1:0]       issue_rd_in
);

    rf_state_e        state;
    logic [AW-1:0]    clr_idx;
    logic [NREGS-1:0] busy;
    logic [XLEN-1:0]  regs [NREGS];
    logic             run;
    logic [NWP-1:0]   wr_eff;

    assign run          = (state == RF_RUN);
    assign rf_ready_out = run;

    // A write is effective only in RUN and only to a non-zero register.
    for (genvar p = 0; p < NWP; p++) begin : g_wr_eff
        assign wr_eff[p] = run && wr_en_in[p] && (wr_addr_in[p*AW +: AW] != '0);
    end

    // Clear FSM: sweep clr_idx over every register, then run until a clear request.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        // NOTE: sequential state uses non-blocking assignments so every block sees pre-edge values.
        if (!ms_riscv32_mp_rst_n_in) begin
            state   <= RF_CLEAR;
            clr_idx <= '0;
        end else if (state == RF_CLEAR) begin
            if (clear_req_in) begin
                clr_idx <= '0;
            end else if (clr_idx == AW'(NREGS - 1)) begin
                state   <= RF_RUN;
                clr_idx <= '0;
            end else begin
                clr_idx <= clr_idx + AW'(1);
            end
        end else if (clear_req_in) begin
            state   <= RF_CLEAR;
            clr_idx <= '0;
        end
    end

    // Storage: zero one register per cycle while clearing, otherwise apply writebacks.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        // NOTE: the array has no reset; the clear sweep zeroes it, so it can map onto plain RAM.
        if (state == RF_CLEAR) begin
            regs[clr_idx] <= '0;
        end else begin
            // Load port is applied last so it wins a same-address collision.
            for (int p = 0; p < NWP; p++) begin
                if (wr_eff[p]) begin
                    regs[wr_addr_in[p*AW +: AW]] <= wr_data_in[p*XLEN +: XLEN];
                end
            end
        end
    end

    // Scoreboard: writebacks clear pending bits, issue sets one; issue applied last wins.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            busy <= '0;
        end else if (!run || clear_req_in) begin
            busy <= '0;
        end else begin
            for (int p = 0; p < NWP; p++) begin
                if (wr_eff[p]) begin
                    busy[wr_addr_in[p*AW +: AW]] <= 1'b0;
                end
            end
            if (issue_en_in && (issue_rd_in != '0)) begin
                busy[issue_rd_in] <= 1'b1;
            end
        end
    end

    // One read path per port.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rs_addr_in[k*AW +: AW];

        msrv32_rf_read_port #(
            .XLEN (XLEN),
            .AW   (AW)
        ) u_rd (
            .run         (run),
            .rs_addr     (addr),
            .stored_data (regs[addr]),
            .stored_busy (busy[addr]),
            .wr_eff      (wr_eff),
            .wr_addr     (wr_addr_in),
            .wr_data     (wr_data_in),
            .rs_data     (rs_data_out[k*XLEN +: XLEN]),
            .rs_busy     (rs_busy_out[k])
        );
    end

endmodule

// File: tb/tb_msrv32_reg_file_sb.sv
// Scoreboard bench for msrv32_reg_file_sb: a driver applies stimulus on the
// falling edge and queues the expected outputs from a behavioural model; a
// monitor samples the DUT shortly afterwards and compares. A second small
// instance (NREGS=16, NRD=4) tracks the shorter sweep length.
module tb_msrv32_reg_file_sb;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NRD    = 2;
    localparam int AW     = 5;
    localparam int NREGS2 = 16;
    localparam int NRD2   = 4;
    localparam int AW2    = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                clear_req;
    logic                rf_ready;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic [1:0]          wr_en;
    logic [2*AW-1:0]     wr_addr;
    logic [2*XLEN-1:0]   wr_data;
    logic                issue_en;
    logic [AW-1:0]       issue_rd;

    logic                 rf_ready2;
    logic [NRD2*AW2-1:0]  rs_addr2;
    logic [NRD2*XLEN-1:0] rs_data2;
    logic [NRD2-1:0]      rs_busy2;

    always #5 clk = ~clk;

    msrv32_reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .clear_req_in           (clear_req),
        .rf_ready_out           (rf_ready),
        .rs_addr_in             (rs_addr),
        .rs_data_out            (rs_data),
        .rs_busy_out            (rs_busy),
        .wr_en_in               (wr_en),
        .wr_addr_in             (wr_addr),
        .wr_data_in             (wr_data),
        .issue_en_in            (issue_en),
        .issue_rd_in            (issue_rd)
    );

    msrv32_reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS2), .NRD(NRD2)) dut2 (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .clear_req_in           (clear_req),
        .rf_ready_out           (rf_ready2),
        .rs_addr_in             (rs_addr2),
        .rs_data_out            (rs_data2),
        .rs_busy_out            (rs_busy2),
        .wr_en_in               (2'b00),
        .wr_addr_in             ({2*AW2{1'b0}}),
        .wr_data_in             ({2*XLEN{1'b0}}),
        .issue_en_in            (1'b0),
        .issue_rd_in            ({AW2{1'b0}})
    );

    typedef struct packed {
        int                  cyc;
        logic                ready;
        logic [NRD-1:0]      busy;
        logic [NRD*XLEN-1:0] data;
        logic                ready2;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;

    // Stimulus for the next cycle.
    logic            s_rst_n;
    logic            s_clr;
    logic [AW-1:0]   s_rs [NRD];
    logic [1:0]      s_we;
    logic [AW-1:0]   s_wa [2];
    logic [XLEN-1:0] s_wd [2];
    logic            s_iss;
    logic [AW-1:0]   s_ird;
    logic [NRD2*AW2-1:0] s_rs2;

    // Reference model: architectural contents, pending flags, edges left until ready.
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];
    int              left;
    int              left2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp, input int cyc);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic idle();
        s_rst_n = 1'b1;
        s_clr   = 1'b0;
        s_we    = 2'b00;
        s_iss   = 1'b0;
        s_ird   = '0;
        for (int p = 0; p < 2; p++) begin
            s_wa[p] = '0;
            s_wd[p] = '0;
        end
    endtask

    task automatic model_reset();
        left  = NREGS;
        left2 = NREGS2;
        for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Drive one cycle at the falling edge, queue the expected outputs, advance the model.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cycle++;
        rst_n     = s_rst_n;
        clear_req = s_clr;
        wr_en     = s_we;
        issue_en  = s_iss;
        issue_rd  = s_ird;
        rs_addr2  = s_rs2;
        for (int k = 0; k < NRD; k++) rs_addr[k*AW +: AW] = s_rs[k];
        for (int p = 0; p < 2; p++) begin
            wr_addr[p*AW +: AW]     = s_wa[p];
            wr_data[p*XLEN +: XLEN] = s_wd[p];
        end

        if (!s_rst_n) model_reset();

        e.cyc    = cycle;
        e.ready  = s_rst_n && (left == 0);
        e.ready2 = s_rst_n && (left2 == 0);
        for (int k = 0; k < NRD; k++) begin
            logic [XLEN-1:0] d;
            logic            b;
            d = '0;
            b = 1'b0;
            if (e.ready && s_rs[k] != 0) begin
                if (s_we[1] && s_wa[1] == s_rs[k]) d = s_wd[1];
                else if (s_we[0] && s_wa[0] == s_rs[k]) d = s_wd[0];
                else begin
                    d = m_regs[s_rs[k]];
                    b = m_busy[s_rs[k]];
                end
            end
            e.data[k*XLEN +: XLEN] = d;
            e.busy[k]              = b;
        end
        exp_q.push_back(e);

        if (s_rst_n) begin
            if (left2 > 0) left2 = s_clr ? NREGS2 : left2 - 1;
            else if (s_clr) left2 = NREGS2;

            if (left > 0) begin
                left = s_clr ? NREGS : left - 1;
            end else if (s_clr) begin
                model_reset();
                left2 = NREGS2;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (s_we[p] && s_wa[p] != 0) begin
                        m_regs[s_wa[p]] = s_wd[p];
                        m_busy[s_wa[p]] = 1'b0;
                    end
                end
                if (s_iss && s_ird != 0) m_busy[s_ird] = 1'b1;
            end
        end
    endtask

    // Monitor: compare DUT outputs against the queued expectations, away from the clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ready", 64'(rf_ready), 64'(e.ready), e.cyc);
                check("busy", 64'(rs_busy), 64'(e.busy), e.cyc);
                for (int k = 0; k < NRD; k++)
                    check($sformatf("rs%0d_data", k), 64'(rs_data[k*XLEN +: XLEN]),
                          64'(e.data[k*XLEN +: XLEN]), e.cyc);
                check("ready_16", 64'(rf_ready2), 64'(e.ready2), e.cyc);
                check("data_16", 64'(rs_data2 != '0), 64'(0), e.cyc);
                check("busy_16", 64'(rs_busy2), 64'(0), e.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        clear_req = 1'b0;
        rs_addr   = '0;
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        issue_en  = 1'b0;
        issue_rd  = '0;
        rs_addr2  = '0;
        s_rs2     = '0;
        for (int k = 0; k < NRD; k++) s_rs[k] = '0;
        idle();
        model_reset();

        // Reset, release, sweep all reads through the clear period and beyond.
        s_rst_n = 1'b0;
        repeat (3) tick();
        s_rst_n = 1'b1;
        for (int i = 0; i < 36; i++) begin
            s_rs[0] = AW'(i);
            s_rs[1] = AW'(31 - (i % 32));
            s_rs2   = $urandom;
            tick();
        end

        // Bypass then stored value for x5.
        idle(); s_we = 2'b01; s_wa[0] = 5; s_wd[0] = 32'hDEADBEEF; s_rs[0] = 5; s_rs[1] = 5; tick();
        idle(); tick();

        // Same-address dual write: load port wins; x0 write discarded.
        idle(); s_we = 2'b11; s_wa[0] = 7; s_wd[0] = 32'h1111; s_wa[1] = 7; s_wd[1] = 32'h2222;
        s_rs[0] = 7; s_rs[1] = 7; tick();
        idle(); tick();
        idle(); s_we = 2'b01; s_wa[0] = 0; s_wd[0] = 32'hFFFF; s_rs[0] = 0; s_rs[1] = 7; tick();
        idle(); tick();

        // Scoreboard: issue, writeback clear, issue-vs-write collision.
        idle(); s_iss = 1'b1; s_ird = 9; s_rs[0] = 9; s_rs[1] = 9; tick();
        idle(); tick();
        idle(); s_we = 2'b10; s_wa[1] = 9; s_wd[1] = 32'h99; tick();
        idle(); tick();
        idle(); s_iss = 1'b1; s_ird = 9; s_we = 2'b01; s_wa[0] = 9; s_wd[0] = 32'h1234; tick();
        idle(); repeat (2) tick();

        // Clear request after x3 = 0xA5; writes and issues during the sweep are ignored.
        idle(); s_we = 2'b01; s_wa[0] = 3; s_wd[0] = 32'hA5; tick();
        idle(); s_clr = 1'b1; s_rs[0] = 3; s_rs[1] = 4; tick();
        for (int i = 0; i < 32; i++) begin
            idle(); s_we = 2'b11; s_wa[0] = 3; s_wd[0] = $urandom; s_wa[1] = 4; s_wd[1] = $urandom;
            s_iss = 1'b1; s_ird = 3;
            tick();
        end
        idle(); repeat (3) tick();

        // Reset asserted mid-sweep, then a full sweep from the start.
        idle(); s_clr = 1'b1; tick();
        idle(); repeat (10) tick();
        s_rst_n = 1'b0; repeat (2) tick();
        idle(); repeat (35) tick();

        // Randomised traffic, biased to a few registers to force collisions.
        for (int i = 0; i < 3000; i++) begin
            s_rst_n = ($urandom_range(0, 799) != 0);
            s_clr   = ($urandom_range(0, 149) == 0);
            for (int k = 0; k < NRD; k++)
                s_rs[k] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            s_we = 2'($urandom);
            for (int p = 0; p < 2; p++) begin
                s_wa[p] = AW'($urandom_range(0, 7));
                s_wd[p] = $urandom;
            end
            s_iss = 1'($urandom);
            s_ird = AW'($urandom_range(0, 7));
            s_rs2 = $urandom;
            tick();
        end

        repeat (2) @(negedge clk);
        #5;
        check("queue_drained", 64'(exp_q.size()), 64'(0), cycle);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
